adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//  Sequences ADC sampling and acquisition for the oscilloscope front end, all on one system clock.
//  Makes sample ticks from a clock-enable divider, with no derived clock.
//  Issues one-cycle ADC start strobes and waits for the ADC done handshake.
//  Detects a level trigger and writes DEPTH post-trigger samples into the sample RAM.
//  Sits between the ADC interface and the sample buffer read by the display path.
// PARAMETERS
//  DATA_W  12    ADC sample width
//  DIV_W   16    width of sample-rate divider
//  DEPTH   1024  samples per capture (power of 2); ADDR_W = $clog2(DEPTH)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  arm         in   1       start acquisition (pulse)
//  abort       in   1       cancel acquisition, return to IDLE (pulse)
//  force_trig  in   1       trigger on next sample regardless of level
//  trig_rising in   1       1 = rising-edge trigger, 0 = falling-edge trigger
//  trig_level  in   DATA_W  trigger threshold, unsigned
//  div_cfg     in   DIV_W   sample period in clk cycles; 0 is treated as 1
//  adc_start   out  1       one-cycle conversion request to ADC
//  adc_done    in   1       one-cycle pulse: adc_data valid
//  adc_data    in   DATA_W  conversion result
//  wr_en       out  1       sample RAM write strobe
//  wr_addr     out  ADDR_W  sample RAM address
//  wr_data     out  DATA_W  sample RAM data
//  busy        out  1       high in WAIT_TRIG or CAPTURE
//  done        out  1       high in DONE
//  overrun     out  1       sticky: a sample tick was dropped; cleared on arm
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Divider, address, pending flag and prev-sample-valid flag are 0.
//  States: IDLE, WAIT_TRIG, CAPTURE, DONE.
//   IDLE      -arm->       WAIT_TRIG
//   WAIT_TRIG -trigger->   CAPTURE
//   CAPTURE   -last write-> DONE
//   DONE      -arm->       WAIT_TRIG
//   abort in any state -> IDLE on the next edge. abort wins over arm in the same cycle.
//   arm in WAIT_TRIG or CAPTURE is ignored.
//  Arming: div_cfg is latched into div_q, where 0 becomes 1.
//   Arming also clears the divider, wr_addr, overrun and the prev-sample-valid flag.
//  Divider: runs only in WAIT_TRIG and CAPTURE. It counts 0..div_q-1 and wraps to 0.
//   tick is asserted when the count equals div_q-1, so div_q=1 gives a tick every cycle.
//   The first tick comes div_q cycles after the arm edge.
//  ADC handshake:
//   adc_start=1 for one cycle on a tick, if no conversion is pending or adc_done is high that cycle.
//   adc_start sets pending. adc_done clears pending.
//   A tick while pending, with no adc_done that cycle, is dropped and sets overrun.
//   adc_done is ignored in IDLE and DONE. A stray late done after abort has no effect.
//  Trigger, evaluated on each adc_done in WAIT_TRIG:
//   rising:  prev < trig_level  && cur >= trig_level
//   falling: prev >= trig_level && cur < trig_level
//   Requires prev valid, so the first sample after arm never triggers on level.
//   force_trig held high triggers on the next adc_done.
//   The triggering sample is itself written at address 0.
//  Capture:
//   Each accepted sample (trigger sample, then every adc_done in CAPTURE) is registered.
//   Write latency is 1 cycle: adc_done at cycle t gives wr_en=1 at t+1, carrying that sample.
//   Addresses are written 0,1,..,DEPTH-1 with no wrap.
//   The write to DEPTH-1 moves the state to DONE on the same edge that asserts it.
//   wr_addr holds its last value when idle. wr_en is never high in IDLE or DONE except for that final write.
//  Reset mid-capture: immediate return to reset values. RAM contents are not touched.
// TESTING
//  1) div_cfg=4, ADC model done 2 cycles after start, arm
//     -> adc_start every 4 cycles, first one 4 cycles after arm; overrun stays 0.
//  2) Rising trigger, trig_level=0x800, samples 0x700,0x7F0,0x810,0x820
//     -> wr_en with addr0=0x810, addr1=0x820; no write before 0x810.
//  3) DEPTH=8, force_trig=1, samples 1..10
//     -> writes addr0..7 = 1..8; done=1 and busy=0 right after the addr 7 write; sample 9 is not written.
//  4) div_cfg=0, ADC latency 3
//     -> ticks every cycle, adc_start every 3 cycles, overrun=1 after the first dropped tick.
//  5) abort during CAPTURE at addr 3, late adc_done follows
//     -> IDLE, no further wr_en; arm+abort in the same cycle stays in IDLE.
//  6) rst asserted mid-WAIT_TRIG, asynchronously between edges
//     -> all outputs 0 immediately; falling trigger 0x900->0x100 works after re-arm.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// ADC acquisition sequencer: clock-enable sample divider, start/done handshake,
// level/forced trigger and DEPTH-sample post-trigger write into the sample RAM.
module adc_capture_ctrl #(
    parameter  int DATA_W = 12,
    parameter  int DIV_W  = 16,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              force_trig_i,
    input  logic              trig_rising_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic [DIV_W-1:0]  div_cfg_i,
    output logic              adc_start_o,
    input  logic              adc_done_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d, cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                active, tick, done_acc, arm_ok, lvl_hit, trig, wr, last, start;
    logic [ADDR_W-1:0]   waddr;

    assign active   = (state_q == S_WAIT) || (state_q == S_CAP);
    assign tick     = active && (cnt_q == div_q - DIV_W'(1));
    assign done_acc = active && adc_done_i;
    assign arm_ok   = arm_i && !abort_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign lvl_hit  = trig_rising_i ? (prev_q <  trig_level_i && adc_data_i >= trig_level_i)
                                    : (prev_q >= trig_level_i && adc_data_i <  trig_level_i);
    assign trig     = (state_q == S_WAIT) && done_acc && (force_trig_i || (prev_vld_q && lvl_hit));
    assign wr       = !abort_i && (trig || ((state_q == S_CAP) && done_acc));
    assign waddr    = (state_q == S_CAP) ? wr_addr_q + ADDR_W'(1) : '0;
    assign last     = (waddr == ADDR_W'(DEPTH - 1));
    // A done arriving with the tick frees the ADC for the new request in the same cycle.
    assign start    = tick && !abort_i && (!pending_q || adc_done_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (arm_i) state_d = S_WAIT;
                S_WAIT:  if (trig) state_d = last ? S_DONE : S_CAP;
                S_CAP:   if (wr && last) state_d = S_DONE;
                S_DONE:  if (arm_i) state_d = S_WAIT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = active;
        done_o      = (state_q == S_DONE);
        adc_start_o = start;
        wr_en_o     = wr_en_q;
        wr_addr_o   = wr_addr_q;
        wr_data_o   = wr_data_q;
        overrun_o   = overrun_q;
    end

    always_comb begin
        div_d      = div_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en_d    = wr;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (wr) begin
            wr_addr_d = waddr;
            wr_data_d = adc_data_i;
        end
        // Pending is dropped on arm/abort so a conversion lost across IDLE can't stall the next run.
        if (arm_ok) begin
            div_d      = (div_cfg_i == '0) ? DIV_W'(1) : div_cfg_i;
            cnt_d      = '0;
            pending_d  = 1'b0;
            overrun_d  = 1'b0;
            prev_vld_d = 1'b0;
            wr_addr_d  = '0;
        end else if (abort_i) begin
            pending_d = 1'b0;
        end else if (active) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            if (start)           pending_d = 1'b1;
            else if (adc_done_i) pending_d = 1'b0;
            if (tick && pending_q && !adc_done_i) overrun_d = 1'b1;
            if (state_q == S_WAIT && adc_done_i) begin
                prev_d     = adc_data_i;
                prev_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (DEPTH=8) with a latency-programmable ADC model.
module tb_adc_capture_ctrl;
    localparam int DW = 12, VW = 16, DEP = 8, AW = 3;

    logic          clk = 0, rst = 1, arm = 0, abort = 0, force_trig = 0, trig_rising = 1;
    logic [DW-1:0] trig_level = '0;
    logic [VW-1:0] div_cfg = '0;
    logic          adc_start, adc_done = 0;
    logic [DW-1:0] adc_data = '0;
    logic          wr_en, busy, done, overrun;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0, errors = 0;
    int cyc = 0, arm_cyc = 0;

    adc_capture_ctrl #(.DATA_W(DW), .DIV_W(VW), .DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .abort_i(abort), .force_trig_i(force_trig),
        .trig_rising_i(trig_rising), .trig_level_i(trig_level), .div_cfg_i(div_cfg),
        .adc_start_o(adc_start), .adc_done_i(adc_done), .adc_data_i(adc_data),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .done_o(done), .overrun_o(overrun));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: done (with the next sample) lat cycles after each sampled start.
    int            lat = 2, cd = 0, si = 0;
    logic [DW-1:0] smp [0:15];
    logic          mdl_rst = 0;
    always @(negedge clk) begin
        adc_done = 1'b0;
        if (mdl_rst) begin
            cd = 0; si = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                adc_done = 1'b1;
                adc_data = (si < 16) ? smp[si] : '0;
                si++;
            end
        end
        #1;
        if (!mdl_rst && adc_start === 1'b1) cd = lat;
    end

    // Event log, sampled mid-cycle.
    logic mon_clr = 0;
    int   nw = 0, nst = 0, ldc = 0;
    int   wa [0:31], wd [0:31], wc [0:31], wdc [0:31], sc [0:31];
    logic wdn [0:31], wbz [0:31];
    always @(negedge clk) begin
        #2;
        if (mon_clr) begin
            nw = 0; nst = 0;
        end else begin
            if (wr_en === 1'b1 && nw < 32) begin
                wa[nw] = int'(wr_addr); wd[nw] = int'(wr_data); wc[nw] = cyc;
                wdc[nw] = ldc; wdn[nw] = done; wbz[nw] = busy;
                nw++;
            end
            if (adc_start === 1'b1 && nst < 32) begin
                sc[nst] = cyc; nst++;
            end
            if (adc_done) ldc = cyc;
        end
    end

    task automatic clr_tb();
        @(negedge clk); #3;
        mdl_rst = 1; mon_clr = 1;
        @(negedge clk); #3;
        mdl_rst = 0; mon_clr = 0;
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1; arm_cyc = cyc;
        @(negedge clk);
        arm = 0;
    endtask

    task automatic do_abort();
        @(negedge clk); abort = 1;
        @(negedge clk); abort = 0;
    endtask

    task automatic wait_nw(input int n, input int budget, output bit ok);
        int b = 0;
        while (nw < n && b < budget) begin @(negedge clk); #3; b++; end
        ok = (nw >= n);
    endtask

    task automatic wait_nst(input int n, input int budget, output bit ok);
        int b = 0;
        while (nst < n && b < budget) begin @(negedge clk); #3; b++; end
        ok = (nst >= n);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #3;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_state busy=%b done=%b exp 0 0", busy, done); end
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
        #3;
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", adc_start); end
        checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL reset_wr en=%b addr=%h data=%h exp 0", wr_en, wr_addr, wr_data); end
        checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags ov=%b busy=%b exp 0 0", overrun, busy); end
    endtask

    task automatic test_sample_rate();
        bit ok;
        clr_tb();
        for (int i = 0; i < 16; i++) smp[i] = '0;
        div_cfg = 16'd4; lat = 2; trig_rising = 1; trig_level = 12'hFFF; force_trig = 0;
        do_arm();
        wait_nst(3, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rate_timeout starts=%0d exp 3", nst); end
        else begin
            checks++; if (sc[0] - arm_cyc !== 4) begin errors++; $display("FAIL rate_first got %0d exp 4", sc[0] - arm_cyc); end
            checks++; if (sc[1] - sc[0] !== 4) begin errors++; $display("FAIL rate_gap1 got %0d exp 4", sc[1] - sc[0]); end
            checks++; if (sc[2] - sc[1] !== 4) begin errors++; $display("FAIL rate_gap2 got %0d exp 4", sc[2] - sc[1]); end
        end
        checks++; if (overrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rate_flags ov=%b busy=%b exp 0 1", overrun, busy); end
    endtask

    task automatic test_rising_trigger();
        bit ok;
        do_abort();
        clr_tb();
        smp[0] = 12'h700; smp[1] = 12'h7F0; smp[2] = 12'h810; smp[3] = 12'h820;
        for (int i = 4; i < 16; i++) smp[i] = 12'h830 + 12'(i);
        div_cfg = 16'd4; lat = 2; trig_rising = 1; trig_level = 12'h800; force_trig = 0;
        do_arm();
        wait_nw(2, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rise_timeout writes=%0d exp 2", nw); end
        else begin
            checks++; if (wa[0] !== 0 || wd[0] !== 'h810) begin errors++; $display("FAIL rise_w0 addr=%0d data=%h exp 0 810", wa[0], wd[0]); end
            checks++; if (wa[1] !== 1 || wd[1] !== 'h820) begin errors++; $display("FAIL rise_w1 addr=%0d data=%h exp 1 820", wa[1], wd[1]); end
            checks++; if (wc[0] - wdc[0] !== 1) begin errors++; $display("FAIL rise_latency got %0d exp 1", wc[0] - wdc[0]); end
            checks++; if (wbz[0] !== 1'b1) begin errors++; $display("FAIL rise_busy got %b exp 1", wbz[0]); end
        end
    endtask

    task automatic test_depth_done();
        bit ok;
        do_abort();
        clr_tb();
        for (int i = 0; i < 16; i++) smp[i] = 12'(i + 1);
        div_cfg = 16'd4; lat = 2; force_trig = 1;
        do_arm();
        wait_nw(8, 150, ok);
        checks++; if (!ok) begin errors++; $display("FAIL depth_timeout writes=%0d exp 8", nw); end
        repeat (30) @(negedge clk);
        #3;
        force_trig = 0;
        checks++; if (nw !== 8) begin errors++; $display("FAIL depth_count got %0d exp 8", nw); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (wa[i] !== i || wd[i] !== i + 1) begin errors++; $display("FAIL depth_w%0d addr=%0d data=%0d exp %0d %0d", i, wa[i], wd[i], i, i + 1); end
        end
        checks++; if (wdn[7] !== 1'b1 || wbz[7] !== 1'b0) begin errors++; $display("FAIL depth_last done=%b busy=%b exp 1 0", wdn[7], wbz[7]); end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL depth_hold done=%b busy=%b wr_en=%b exp 1 0 0", done, busy, wr_en); end
    endtask

    task automatic test_overrun();
        bit ok;
        clr_tb();
        for (int i = 0; i < 16; i++) smp[i] = '0;
        div_cfg = 16'd0; lat = 3; trig_rising = 1; trig_level = 12'hFFF; force_trig = 0;
        do_arm();
        wait_nst(3, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout starts=%0d exp 3", nst); end
        else begin
            checks++; if (sc[0] - arm_cyc !== 1) begin errors++; $display("FAIL ovr_first got %0d exp 1", sc[0] - arm_cyc); end
            checks++; if (sc[1] - sc[0] !== 3 || sc[2] - sc[1] !== 3) begin errors++; $display("FAIL ovr_gaps got %0d %0d exp 3 3", sc[1] - sc[0], sc[2] - sc[1]); end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    endtask

    task automatic test_abort();
        bit ok;
        int st0;
        do_abort();
        clr_tb();
        for (int i = 0; i < 16; i++) smp[i] = 12'h11 + 12'(i);
        div_cfg = 16'd4; lat = 3; force_trig = 1;
        do_arm();
        repeat (2) @(negedge clk);
        #3;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_ovclr got %b exp 0", overrun); end
        wait_nw(4, 100, ok);
        checks++; if (!ok || wa[3] !== 3 || wd[3] !== 'h14) begin errors++; $display("FAIL abort_pre writes=%0d addr3=%0d data3=%h exp 4 3 14", nw, wa[3], wd[3]); end
        do_abort();
        force_trig = 0;
        #3;
        st0 = nst;
        repeat (20) @(negedge clk);
        #3;
        checks++; if (nw !== 4) begin errors++; $display("FAIL abort_nowrite got %0d exp 4", nw); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (nst !== st0) begin errors++; $display("FAIL abort_nostart got %0d exp %0d", nst, st0); end
        @(negedge clk); arm = 1; abort = 1;
        @(negedge clk); arm = 0; abort = 0;
        repeat (6) @(negedge clk);
        #3;
        checks++; if (busy !== 1'b0 || nst !== st0) begin errors++; $display("FAIL abort_armwin busy=%b starts=%0d exp 0 %0d", busy, nst, st0); end
    endtask

    task automatic test_async_reset();
        bit ok;
        clr_tb();
        for (int i = 0; i < 16; i++) smp[i] = '0;
        div_cfg = 16'd1; lat = 3; trig_rising = 1; trig_level = 12'hFFF; force_trig = 0;
        do_arm();
        repeat (10) @(negedge clk);
        #1;
        checks++; if (overrun !== 1'b1 || busy !== 1'b1 || wr_data !== 12'h14) begin errors++; $display("FAIL ares_pre ov=%b busy=%b data=%h exp 1 1 14", overrun, busy, wr_data); end
        #2; rst = 1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ares_flags busy=%b done=%b ov=%b exp 0", busy, done, overrun); end
        checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL ares_wr en=%b addr=%h data=%h exp 0", wr_en, wr_addr, wr_data); end
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL ares_start got %b exp 0", adc_start); end
        @(negedge clk); rst = 0;
        clr_tb();
        smp[0] = 12'h900; smp[1] = 12'h100; smp[2] = 12'h050;
        div_cfg = 16'd4; lat = 2; trig_rising = 0; trig_level = 12'h800;
        do_arm();
        wait_nw(1, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fall_timeout writes=%0d exp 1", nw); end
        else begin
            checks++; if (wa[0] !== 0 || wd[0] !== 'h100) begin errors++; $display("FAIL fall_w0 addr=%0d data=%h exp 0 100", wa[0], wd[0]); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fall_busy got %b exp 1", busy); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) smp[i] = '0;
        test_reset();
        test_sample_rate();
        test_rising_trigger();
        test_depth_done();
        test_overrun();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
